// File: rtl/dcsk_pkg.sv
// Shared DCSK definitions: chip type, spreading-factor select, FSM states and
// width constants used by both the transmitter and the correlator demodulator.
package dcsk_pkg;

   localparam int CHIP_W   = 8;
   localparam int ACC_W    = 24;
   localparam int MAX_BETA = 64;

   typedef logic signed [CHIP_W-1:0] chip_t;
   typedef logic [1:0]               sf_sel_t;

   // Half-symbol phase: reference chips first, then data chips.
   typedef enum logic {
      REF  = 1'b0,
      DATA = 1'b1
   } state_e;

   // Half-symbol length for a spreading-factor select code: 8/16/32/64.
   function automatic logic [6:0] beta_of(input sf_sel_t sel);
      logic [6:0] b;
      case (sel)
         2'b00:   b = 7'd8;
         2'b01:   b = 7'd16;
         2'b10:   b = 7'd32;
         default: b = 7'd64;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dcsk_ref_buf.sv
// Reference-half chip storage: synchronous write, combinational read.
// Storage needs no reset because every location is written before it is read.
module dcsk_ref_buf
   import dcsk_pkg::*;
#(
   parameter int CHIP_W   = dcsk_pkg::CHIP_W,
   parameter int MAX_BETA = dcsk_pkg::MAX_BETA,
   parameter int ADDR_W   = $clog2(MAX_BETA)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic signed [CHIP_W-1:0] wdata,
   input  logic [ADDR_W-1:0]        raddr,
   output logic signed [CHIP_W-1:0] rdata
);

   logic signed [CHIP_W-1:0] mem [MAX_BETA];

   // Write port: capture one reference chip per accepted REF cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dcsk_corr_demod.sv
// Non-coherent DCSK correlator demodulator. Stores the reference half of each
// symbol, correlates it against the data half, decides the bit from the sign
// of the correlation and packs decided bits MSB-first into 32-bit words.
//
// Handshake: Chip_In is consumed on every rising edge where Chip_Valid is 1
// (no back-pressure); Bit_Valid and Valid_Data are single-cycle strobes that
// qualify Bit_Out and Out_Data, which hold their values between strobes.
module dcsk_corr_demod
   import dcsk_pkg::*;
#(
   parameter int CHIP_W   = dcsk_pkg::CHIP_W,
   parameter int MAX_BETA = dcsk_pkg::MAX_BETA,
   parameter int ACC_W    = dcsk_pkg::ACC_W
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic signed [CHIP_W-1:0] Chip_In,
   input  logic                     Chip_Valid,
   input  logic [1:0]               Spread_Factor_Sel,
   input  logic                     Frame_Start,
   output logic                     Bit_Out,
   output logic                     Bit_Valid,
   output logic [31:0]              Out_Data,
   output logic                     Valid_Data,
   output logic                     Dbg_State
);

   localparam int IDX_W  = $clog2(MAX_BETA);
   localparam int PROD_W = 2 * CHIP_W;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        beta_m1_q, beta_m1_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [31:0]             shift_q, shift_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic                    bit_out_q, bit_out_d;
   logic                    bit_valid_q, bit_valid_d;
   logic [31:0]             out_data_q, out_data_d;
   logic                    valid_data_q, valid_data_d;

   logic                     buf_we;
   logic signed [CHIP_W-1:0] ref_chip;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic [IDX_W-1:0]         sel_last;
   logic [IDX_W-1:0]         ref_last;
   logic                     dec_bit;
   logic [31:0]              shift_next;

   dcsk_ref_buf #(
      .CHIP_W   (CHIP_W),
      .MAX_BETA (MAX_BETA),
      .ADDR_W   (IDX_W)
   ) u_ref_buf (
      .clk   (Clk),
      .we    (buf_we),
      .waddr (idx_q),
      .wdata (Chip_In),
      .raddr (idx_q),
      .rdata (ref_chip)
   );

   // Datapath: signed product, full correlation sum and its sign decision.
   always_comb begin
      prod       = Chip_In * ref_chip;
      sum        = acc_q + ACC_W'(prod);
      dec_bit    = ~sum[ACC_W-1];
      shift_next = {shift_q[30:0], dec_bit};
      sel_last   = IDX_W'(beta_of(Spread_Factor_Sel) - 7'd1);
      // On the first reference chip the freshly selected length applies.
      ref_last   = (idx_q == '0) ? sel_last : beta_m1_q;
   end

   // Next-state and output logic; Frame_Start outranks Chip_Valid.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      beta_m1_d    = beta_m1_q;
      acc_d        = acc_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      bit_out_d    = bit_out_q;
      bit_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      valid_data_d = 1'b0;
      buf_we       = 1'b0;

      if (Frame_Start) begin
         state_d   = REF;
         idx_d     = '0;
         acc_d     = '0;
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (Chip_Valid) begin
         case (state_q)
            REF: begin
               buf_we = 1'b1;
               if (idx_q == '0) begin
                  beta_m1_d = sel_last;
               end
               if (idx_q == ref_last) begin
                  idx_d   = '0;
                  acc_d   = '0;
                  state_d = DATA;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            DATA: begin
               if (idx_q == beta_m1_q) begin
                  bit_out_d   = dec_bit;
                  bit_valid_d = 1'b1;
                  shift_d     = shift_next;
                  bit_cnt_d   = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 5'd31) begin
                     out_data_d   = shift_next;
                     valid_data_d = 1'b1;
                  end
                  idx_d   = '0;
                  acc_d   = '0;
                  state_d = REF;
               end else begin
                  acc_d = sum;
                  idx_d = idx_q + 1'b1;
               end
            end
            default: begin
               state_d = REF;
               idx_d   = '0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= REF;
         idx_q        <= '0;
         beta_m1_q    <= IDX_W'(7);
         acc_q        <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         bit_out_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         out_data_q   <= '0;
         valid_data_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         beta_m1_q    <= beta_m1_d;
         acc_q        <= acc_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         out_data_q   <= out_data_d;
         valid_data_q <= valid_data_d;
      end
   end

   assign Bit_Out    = bit_out_q;
   assign Bit_Valid  = bit_valid_q;
   assign Out_Data   = out_data_q;
   assign Valid_Data = valid_data_q;
   assign Dbg_State  = state_q;

endmodule

// File: doc/dcsk_corr_demod.md
# dcsk_corr_demod

Non-coherent DCSK correlator demodulator: the receive-side counterpart of the DCSK transmitter. Takes the received chip stream and stores the reference half of each symbol. It correlates the reference half against the data half, decides each bit from the sign of the correlation, and packs decided bits into 32-bit words. It sits between the channel/ADC sample interface and the modem's word-level output.

## Interface
Parameters:
- CHIP_W, 8, signed chip sample width
- MAX_BETA, 64, maximum half-symbol length (reference buffer depth)
- ACC_W, 24, signed correlation accumulator width

Ports:
- Clk, input, 1, single system clock, rising edge
- Rst, input, 1, reset; asynchronous and active-high
- Chip_In, input, CHIP_W, signed received chip
- Chip_Valid, input, 1, Chip_In is accepted on this edge
- Spread_Factor_Sel, input, 2, half-symbol length beta: 00→8, 01→16, 10→32, 11→64
- Frame_Start, input, 1, synchronous resync; discards any partial symbol and partial word
- Bit_Out, output, 1, decided bit
- Bit_Valid, output, 1, one-cycle strobe qualifying Bit_Out
- Out_Data, output, 32, last completed word, MSB = first decided bit
- Valid_Data, output, 1, one-cycle strobe when Out_Data updates

## Operation
- FSM states: REF and DATA. Reset state is REF with chip index 0.
- **Symbol start.** beta is latched from Spread_Factor_Sel on the edge that accepts the first REF chip (index 0). Changes to Spread_Factor_Sel mid-symbol have no effect until the next symbol.
- **REF state.** Each accepted chip is written to ref_buf[idx] and idx increments. After chip beta−1: idx clears, accumulator clears, and the FSM moves to DATA.
- **DATA state.** Each accepted chip is multiplied, signed, by ref_buf[idx]. The 16-bit product is sign-extended into the ACC_W accumulator and idx increments.
- **Decision.** On the accepted chip at index beta−1 in DATA, the decision uses the full sum (accumulator + current product):
  - bit = 1 if the sum is ≥ 0;
  - bit = 0 if the sum is < 0;
  - a zero sum decides 1.
- **After the decision.** The bit is registered, idx clears and the FSM returns to REF. No idle cycle is inserted, so back-to-back symbols are supported.
- **Arithmetic.** The worst case is 64 × 16384 = 2^20, so ACC_W = 24 never overflows; no saturation logic is needed.
- **Word assembly.** Each decided bit shifts into a 32-bit shift register from the LSB side, so the first bit ends up at bit 31. A 5-bit bit counter tracks progress. On the 32nd bit the full word is copied to Out_Data and the counter wraps to 0.
- **Stalls.** When Chip_Valid = 0, no state, index or accumulator changes; gaps of any length are allowed.
- **Frame_Start.** Has priority over Chip_Valid in the same cycle. It forces REF, idx = 0, clears the accumulator, the shift register and the bit counter, and suppresses that cycle's decision.
  - Out_Data keeps its last completed word.
  - A chip presented in the same cycle as Frame_Start is dropped.
- **Reset.**
  - FSM → REF; idx, accumulator, bit counter and shift register → 0; latched beta → 8.
  - Bit_Out = 0, Bit_Valid = 0, Out_Data = 0, Valid_Data = 0.
  - Reset mid-symbol discards everything. The first chip after reset deasserts is treated as reference chip 0.

## Timing
- Bit_Valid is high for exactly one cycle, on the cycle after the edge that accepts the last data chip. Bit_Out holds until the next decision.
- Valid_Data asserts in the same cycle as Bit_Valid for the 32nd bit of a word. The new Out_Data is visible in that cycle and is held until the next word.
- Symbol throughput: 2·beta accepted chips per bit. Minimum Bit_Valid spacing is 2·beta cycles.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Structure
- Shared package dcsk_pkg holds:
  - chip_t, a signed CHIP_W type;
  - sf_sel_t and the function beta_of(sf_sel_t) returning 8/16/32/64;
  - the FSM enum {REF, DATA};
  - ACC_W and MAX_BETA constants, shared with the transmitter.
- One sub-module: dcsk_ref_buf, a MAX_BETA × CHIP_W register file.
  - Synchronous write port: we, waddr, wdata.
  - Combinational read port: raddr → rdata.
  - No reset is needed on its storage.

## Test plan
- **Same-sign data half.** SF = 00; 8 REF chips alternating +20/−20, then the identical 8 chips as data. Expect Bit_Out = 1 with Bit_Valid one cycle after the 16th chip.
- **Inverted data half, with a mid-symbol SF change.** SF = 01; 16 REF chips of pseudo-random values, then the same chips negated as data. Expect Bit_Out = 0. Changing SF to 11 after chip 5 must not change the 32-chip symbol length.
- **Word assembly, back-to-back, with a zero-sum decision.**
  - SF = 00; 32 symbols with no gaps encoding 0xA5C3_0F0F.
  - Expect Valid_Data for exactly one cycle, coincident with the 32nd Bit_Valid, and Out_Data = 0xA5C3_0F0F.
  - Include one symbol whose data half is all zeros: zero correlation must decide bit 1.
- **Random stalls.** Repeat the word scenario with Chip_Valid deasserted randomly about 40% of the time. Expect an identical Out_Data and the same strobe counts.
- **Frame_Start mid-symbol and mid-word.**
  - Assert Frame_Start after 10 bits plus 5 REF chips.
  - Expect no Bit_Valid for the partial symbol and Out_Data unchanged.
  - Then 32 fresh symbols encoding 0x1234_5678 must produce exactly 0x1234_5678.
- **Asynchronous reset mid-DATA.** Assert Rst asynchronously during a DATA half. All outputs must go to 0 immediately, without waiting for a clock edge. After release, a clean SF = 10 symbol with data = reference decodes to 1.
